// File: rtl/cpu_cu.sv
// ---------------------------------------------------------------------------
// cpu_cu -- control unit for the 16-bit RISC CPU.
//
// Sequences fetch / decode / execute for the execution unit (cpu_eu). It
// decodes the instruction held in the EU's instruction register, keeps a
// private copy of the ALU flags for conditional branches, and drives every
// EU control plus the memory read/write strobes (with a ready handshake).
//
// Instruction fields: class = IR[15:13], sub = IR[12:9],
//                     W = IR[8:6], R = IR[5:3], S = IR[2:0].
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   synchronous, active-high; overrides everything
//   IR_OUT     in   [15:0] instruction register from the EU
//   C, N, Z    in   ALU status from the EU (captured only in EX_ALU)
//   mem_rdy    in   memory completes the current read/write this cycle
//   Alu_Op     out  [3:0] EU ALU operation
//   W_Adr      out  [2:0] EU write register address
//   R_Adr      out  [2:0] EU R-operand register address
//   S_Adr      out  [2:0] EU S-operand register address
//   adr_sel    out  memory address select (0 = PC, 1 = R operand)
//   s_sel      out  S operand select (1 = memory data)
//   reg_w_en   out  register file write enable
//   ir_ld      out  load instruction register
//   pc_ld      out  load PC (branch / jump)
//   pc_inc     out  increment PC
//   pc_sel     out  PC load source (0 = PC + offset, 1 = ALU result)
//   mr_en      out  memory read strobe
//   mw_en      out  memory write strobe
//   halted     out  FSM is in HALT
//   illegal    out  sticky: HALT was entered on an undefined class
//   state      out  [3:0] current state code (debug)
// ---------------------------------------------------------------------------
module cpu_cu #(
    parameter logic [3:0] ALU_PASS_S = 4'h0,
    parameter logic [3:0] ALU_PASS_R = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR_OUT,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    input  logic        mem_rdy,
    output logic [3:0]  Alu_Op,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        adr_sel,
    output logic        s_sel,
    output logic        reg_w_en,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        pc_sel,
    output logic        mr_en,
    output logic        mw_en,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EX_ALU = 4'd3,
        ST_EX_LD  = 4'd4,
        ST_EX_ST  = 4'd5,
        ST_EX_BR  = 4'd6,
        ST_EX_JR  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_LD   = 3'b001;
    localparam logic [2:0] CLS_ST   = 3'b010;
    localparam logic [2:0] CLS_BR   = 3'b011;
    localparam logic [2:0] CLS_JR   = 3'b100;
    localparam logic [2:0] CLS_HALT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] flags_q;     // {c, n, z} from the most recent EX_ALU
    logic       illegal_q;

    logic [2:0] ir_class;
    logic [3:0] ir_sub;
    logic       cls_undefined;
    logic       br_taken;

    assign ir_class      = IR_OUT[15:13];
    assign ir_sub        = IR_OUT[12:9];
    assign cls_undefined = (ir_class == 3'b101) || (ir_class == 3'b110);

    // ------------------------------------------------------------------
    // State, flag and sticky-illegal registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            flags_q   <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Flags are written at the same edge as the ALU result, so the
            // very next branch already sees them.
            if (state_q == ST_EX_ALU)
                flags_q <= {C, N, Z};
            if (state_q == ST_DECODE && cls_undefined)
                illegal_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Branch condition, evaluated against the captured flags only
    // ------------------------------------------------------------------
    always_comb begin
        unique case (ir_sub)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken =  flags_q[2];
            4'd2:    br_taken =  flags_q[1];
            4'd3:    br_taken =  flags_q[0];
            4'd4:    br_taken = ~flags_q[2];
            4'd5:    br_taken = ~flags_q[1];
            4'd6:    br_taken = ~flags_q[0];
            default: br_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    // NOTE: every output and state_d gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        Alu_Op   = 4'h0;
        W_Adr    = 3'd0;
        R_Adr    = 3'd0;
        S_Adr    = 3'd0;
        adr_sel  = 1'b0;
        s_sel    = 1'b0;
        reg_w_en = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_sel   = 1'b0;
        mr_en    = 1'b0;
        mw_en    = 1'b0;
        halted   = 1'b0;

        // Register addresses track the IR from DECODE through execute.
        if (state_q inside {ST_DECODE, ST_EX_ALU, ST_EX_LD, ST_EX_ST,
                            ST_EX_BR, ST_EX_JR}) begin
            W_Adr = IR_OUT[8:6];
            R_Adr = IR_OUT[5:3];
            S_Adr = IR_OUT[2:0];
        end

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                adr_sel = 1'b0;
                mr_en   = 1'b1;
                if (mem_rdy) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (ir_class)
                    CLS_ALU:  state_d = ST_EX_ALU;
                    CLS_LD:   state_d = ST_EX_LD;
                    CLS_ST:   state_d = ST_EX_ST;
                    CLS_BR:   state_d = ST_EX_BR;
                    CLS_JR:   state_d = ST_EX_JR;
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_HALT;  // 101/110: flagged illegal
                endcase
            end

            ST_EX_ALU: begin
                Alu_Op   = ir_sub;
                s_sel    = 1'b0;
                reg_w_en = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_EX_LD: begin
                adr_sel = 1'b1;
                mr_en   = 1'b1;
                if (mem_rdy) begin
                    s_sel    = 1'b1;
                    Alu_Op   = ALU_PASS_S;
                    reg_w_en = 1'b1;
                    state_d  = ST_FETCH;
                end
            end

            ST_EX_ST: begin
                adr_sel = 1'b1;
                Alu_Op  = ALU_PASS_S;
                s_sel   = 1'b0;
                mw_en   = 1'b1;
                if (mem_rdy)
                    state_d = ST_FETCH;
            end

            ST_EX_BR: begin
                // PC already points past the branch; the EU adds sext(IR[7:0]).
                if (br_taken) begin
                    pc_sel = 1'b0;
                    pc_ld  = 1'b1;
                end
                state_d = ST_FETCH;
            end

            ST_EX_JR: begin
                Alu_Op  = ALU_PASS_R;
                pc_sel  = 1'b1;
                pc_ld   = 1'b1;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                // Unreachable codes 9..15 recover into HALT.
                state_d = ST_HALT;
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
